muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl_pkg.sv | 43 ++++
 rtl/muldiv_ctrl.sv | 157 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer beside EX.
// The div handshake levels mirror the DivStart/DivStop and DivResultReady/NotReady constants.
package muldiv_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        MDC_IDLE     = 2'd0,
        MDC_DIV_BUSY = 2'd1,
        MDC_MUL_BUSY = 2'd2,
        MDC_DONE     = 2'd3
    } mdc_state_e;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_DIV   = 3'd1,
        OP_DIVU  = 3'd2,
        OP_MULT  = 3'd3,
        OP_MULTU = 3'd4
    } md_op_e;

    // {remainder, quotient} or {product_hi, product_lo}
    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    // Several request bits together is illegal; resolve as div > divu > mult > multu.
    function automatic md_op_e decode_op(input logic op_div, input logic op_divu,
                                         input logic op_mult, input logic op_multu);
        if (op_div)   return OP_DIV;
        if (op_divu)  return OP_DIVU;
        if (op_mult)  return OP_MULT;
        if (op_multu) return OP_MULTU;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences one mult/multu/div/divu through the shared mul and div units, stalls EX
// until the 64-bit result is in, then issues a single-cycle HI/LO write.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_div,
    input  logic              op_divu,
    input  logic              op_mult,
    input  logic              op_multu,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    input  logic              div_ready,
    input  logic [63:0]       div_result,
    input  logic [63:0]       mul_result,
    output logic              div_start,
    output logic              div_annul,
    output logic              div_signed,
    output logic [DATA_W-1:0] div_opdata1,
    output logic [DATA_W-1:0] div_opdata2,
    output logic              mul_signed,
    output logic [DATA_W-1:0] mul_ina,
    output logic [DATA_W-1:0] mul_inb,
    output logic              stallreq,
    output logic              hi_we,
    output logic              lo_we,
    output logic [DATA_W-1:0] hi_wdata,
    output logic [DATA_W-1:0] lo_wdata,
    output logic              busy
);

    mdc_state_e        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] opa, opb, opa_next, opb_next;
    logic              op_signed, op_signed_next;
    md_op_e            op;
    logic              op_any;
    logic              is_div_op;
    hilo_t             res_next;
    logic              we_q;

    // Next state, operand latch and result capture
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        opa_next       = opa;
        opb_next       = opb;
        op_signed_next = op_signed;
        res_next       = '0;
        op             = decode_op(op_div, op_divu, op_mult, op_multu);
        op_any         = (op != OP_NONE);
        is_div_op      = (op == OP_DIV) || (op == OP_DIVU);

        if (flush) begin
            state_next = MDC_IDLE;
        end else begin
            case (state)
                MDC_IDLE: begin
                    if (op_any) begin
                        opa_next       = src1;
                        opb_next       = src2;
                        op_signed_next = (op == OP_DIV) || (op == OP_MULT);
                        if (is_div_op) begin
                            // Divide by zero never reaches the div unit
                            if (src2 == '0) begin
                                state_next  = MDC_DONE;
                                res_next.hi = src1;
                                res_next.lo = '1;
                            end else begin
                                state_next = MDC_DIV_BUSY;
                            end
                        end else begin
                            state_next = MDC_MUL_BUSY;
                            cnt_next   = CNT_W'(MUL_CYCLES - 1);
                        end
                    end
                end
                MDC_DIV_BUSY: begin
                    if (div_ready == DIV_RESULT_READY) begin
                        state_next = MDC_DONE;
                        res_next   = div_result;
                    end
                end
                MDC_MUL_BUSY: begin
                    if (cnt == '0) begin
                        state_next = MDC_DONE;
                        res_next   = mul_result;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                MDC_DONE: state_next = MDC_IDLE;
                default:  state_next = MDC_IDLE;
            endcase
        end
    end

    assign stallreq = ~flush & (((state == MDC_IDLE) & op_any) |
                                (state == MDC_DIV_BUSY) | (state == MDC_MUL_BUSY));

    // A flush in DONE kills the instruction in EX, so its write is dropped too
    assign hi_we = we_q & ~flush;
    assign lo_we = we_q & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MDC_IDLE;
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            op_signed <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            opa       <= opa_next;
            opb       <= opb_next;
            op_signed <= op_signed_next;
        end
    end

    // Unit-facing and HI/LO outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_start   <= DIV_STOP;
            div_annul   <= 1'b0;
            div_signed  <= 1'b0;
            div_opdata1 <= '0;
            div_opdata2 <= '0;
            mul_signed  <= 1'b0;
            mul_ina     <= '0;
            mul_inb     <= '0;
            we_q        <= 1'b0;
            hi_wdata    <= '0;
            lo_wdata    <= '0;
            busy        <= 1'b0;
        end else begin
            div_start   <= (state_next == MDC_DIV_BUSY) ? DIV_START : DIV_STOP;
            div_annul   <= flush & (state == MDC_DIV_BUSY);
            div_signed  <= (state_next == MDC_DIV_BUSY) & op_signed_next;
            div_opdata1 <= (state_next == MDC_DIV_BUSY) ? opa_next : '0;
            div_opdata2 <= (state_next == MDC_DIV_BUSY) ? opb_next : '0;
            mul_signed  <= (state_next == MDC_MUL_BUSY) & op_signed_next;
            mul_ina     <= (state_next == MDC_MUL_BUSY) ? opa_next : '0;
            mul_inb     <= (state_next == MDC_MUL_BUSY) ? opb_next : '0;
            we_q        <= (state_next == MDC_DONE);
            hi_wdata    <= res_next.hi;
            lo_wdata    <= res_next.lo;
            busy        <= (state_next != MDC_IDLE);
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, multi-cycle corner
// sequences (flush, async reset) and random operations against an arithmetic model.
module tb_muldiv_ctrl;

    localparam int unsigned MUL_CYCLES = 2;

    logic        clk, rst;
    logic        op_div, op_divu, op_mult, op_multu;
    logic [31:0] src1, src2;
    logic        flush;
    logic        div_ready;
    logic [63:0] div_result, mul_result;
    logic        div_start, div_annul, div_signed;
    logic [31:0] div_opdata1, div_opdata2;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic        stallreq, hi_we, lo_we, busy;
    logic [31:0] hi_wdata, lo_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int div_lat  = 33;
    int dcnt;

    muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .op_div(op_div), .op_divu(op_divu), .op_mult(op_mult), .op_multu(op_multu),
        .src1(src1), .src2(src2), .flush(flush),
        .div_ready(div_ready), .div_result(div_result), .mul_result(mul_result),
        .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .stallreq(stallreq), .hi_we(hi_we), .lo_we(lo_we),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Div unit model: result ready in the div_lat-th cycle that div_start is held
    always @(posedge clk or posedge rst) begin
        if (rst)                          dcnt <= 0;
        else if (div_start && !div_ready) dcnt <= dcnt + 1;
        else                              dcnt <= 0;
    end
    assign div_ready = div_start && (dcnt == div_lat - 1);

    always_comb begin
        int q, r;
        div_result = '0;
        if (div_opdata2 != 0) begin
            if (div_signed) begin
                q = int'(div_opdata1) / int'(div_opdata2);
                r = int'(div_opdata1) % int'(div_opdata2);
                div_result = {32'(r), 32'(q)};
            end else begin
                div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
            end
        end
    end

    // Mul unit model
    always_comb begin
        longint p;
        p = longint'(int'(mul_ina)) * longint'(int'(mul_inb));
        if (mul_signed) mul_result = 64'(p);
        else            mul_result = {32'b0, mul_ina} * {32'b0, mul_inb};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: ops = {div, divu, mult, multu}, highest bit wins
    task automatic model(input logic [3:0] ops, input logic [31:0] a, input logic [31:0] b,
                         input int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output int stall, output logic uses_div);
        logic [63:0] prod;
        uses_div = 1'b0;
        if (ops[3] || ops[2]) begin
            if (b == 0) begin
                hi = a; lo = 32'hFFFF_FFFF; stall = 1;
            end else begin
                uses_div = 1'b1;
                stall = 1 + lat;
                if (ops[3]) begin
                    lo = 32'(int'(a) / int'(b));
                    hi = 32'(int'(a) % int'(b));
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        end else begin
            if (ops[1]) prod = 64'(longint'(int'(a)) * longint'(int'(b)));
            else        prod = {32'b0, a} * {32'b0, b};
            hi = prod[63:32];
            lo = prod[31:0];
            stall = 1 + int'(MUL_CYCLES);
        end
    endtask

    task automatic set_ops(input logic [3:0] ops);
        {op_div, op_divu, op_mult, op_multu} = ops;
    endtask

    // Presents one op at the next negedge, holds it through DONE, checks the write
    task automatic run_op(input string tag, input logic [3:0] ops, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_stall, input logic exp_start);
        int   stall = 0;
        bit   done = 0, saw_start = 0, bad_oper = 0;
        logic [31:0] got_hi = '0, got_lo = '0;
        @(negedge clk);
        set_ops(ops); src1 = a; src2 = b; div_lat = lat;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (stallreq) stall++;
            if (div_start) begin
                saw_start = 1;
                if (div_opdata1 !== a || div_opdata2 !== b) bad_oper = 1;
            end
            if (hi_we) begin
                done = 1; got_hi = hi_wdata; got_lo = lo_wdata;
                check({tag, "_lo_we"}, 64'(lo_we), 64'd1);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: got no hi_we expected one within 300 cycles", tag);
        end else begin
            check({tag, "_hi"}, 64'(got_hi), 64'(exp_hi));
            check({tag, "_lo"}, 64'(got_lo), 64'(exp_lo));
            check({tag, "_stall"}, 64'(stall), 64'(exp_stall));
            check({tag, "_div_start"}, 64'(saw_start), 64'(exp_start));
            check({tag, "_div_oper"}, 64'(bad_oper), 64'd0);
        end
    endtask

    // Flushes an op flush_at cycles after it is presented and checks nothing is written
    task automatic flush_seq(input string tag, input logic [3:0] ops, input logic [31:0] a,
                             input logic [31:0] b, input int lat, input int flush_at,
                             input logic exp_annul);
        int we_cnt = 0, annul_cnt = 0;
        @(negedge clk);
        set_ops(ops); src1 = a; src2 = b; div_lat = lat;
        repeat (flush_at) @(negedge clk);
        flush = 1'b1;
        #1;
        check({tag, "_stall_on_flush"}, 64'(stallreq), 64'd0);
        check({tag, "_we_on_flush"}, 64'(hi_we), 64'd0);
        @(negedge clk);
        flush = 1'b0; set_ops(4'b0000);
        #1;
        check({tag, "_annul"}, 64'(div_annul), 64'(exp_annul));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_start_after"}, 64'(div_start), 64'd0);
        check({tag, "_we_after"}, 64'(hi_we | lo_we), 64'd0);
        for (int c = 0; c < lat + 6; c++) begin
            @(negedge clk); #1;
            if (hi_we || lo_we) we_cnt++;
            if (div_annul) annul_cnt++;
        end
        check({tag, "_late_we"}, 64'(we_cnt), 64'd0);
        check({tag, "_annul_len"}, 64'(annul_cnt), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  ops;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] exp_hi, exp_lo;
        int          exp_stall;
        logic        exp_start;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops;
        logic [31:0] a, b, ehi, elo;
        int          lat, estall;
        logic        estart;

        vecs[0] = '{"divu_100_7",   4'b0100, 32'd100,        32'd7, 33, 32'd2,          32'd14,         34, 1'b1};
        vecs[1] = '{"div_neg7_2",   4'b1000, 32'hFFFF_FFF9,  32'd2,  5, 32'hFFFF_FFFF,  32'hFFFF_FFFD,   6, 1'b1};
        vecs[2] = '{"mult_m1_2",    4'b0010, 32'hFFFF_FFFF,  32'd2,  1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,   3, 1'b0};
        vecs[3] = '{"multu_m1_2",   4'b0001, 32'hFFFF_FFFF,  32'd2,  1, 32'h0000_0001,  32'hFFFF_FFFE,   3, 1'b0};
        vecs[4] = '{"div_by_zero",  4'b1000, 32'h0000_1234,  32'd0,  4, 32'h0000_1234,  32'hFFFF_FFFF,   1, 1'b0};
        vecs[5] = '{"prio_div",     4'b1111, 32'hFFFF_FFEC,  32'd6,  3, 32'hFFFF_FFFE,  32'hFFFF_FFFD,   4, 1'b1};
        vecs[6] = '{"prio_mult",    4'b0011, 32'hFFFF_FFFF,  32'd2,  1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,   3, 1'b0};
        vecs[7] = '{"divu_lat1",    4'b0100, 32'hFFFF_FFFF,  32'd16, 1, 32'h0000_000F,  32'h0FFF_FFFF,   2, 1'b1};

        rst = 1'b1; flush = 1'b0; set_ops(4'b0000); src1 = '0; src2 = '0;
        #1;
        check("rst_ctrl", 64'({div_start, div_annul, div_signed, mul_signed, hi_we, lo_we, busy, stallreq}), 64'd0);
        check("rst_data", 64'(div_opdata1 | div_opdata2 | mul_ina | mul_inb | hi_wdata | lo_wdata), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].ops, vecs[i].a, vecs[i].b, vecs[i].lat,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_stall, vecs[i].exp_start);

        // Flush 5 cycles into a divu, then a multu must still work
        flush_seq("flush_divu", 4'b0100, 32'd1000, 32'd3, 33, 5, 1'b1);
        run_op("multu_3x4", 4'b0001, 32'd3, 32'd4, 1, 32'd0, 32'd12, 3, 1'b0);
        flush_seq("flush_vs_ready", 4'b0100, 32'd50, 32'd5, 3, 3, 1'b1);
        flush_seq("flush_vs_cnt0", 4'b0001, 32'd7, 32'd9, 1, int'(MUL_CYCLES), 1'b0);
        flush_seq("flush_idle", 4'b1000, 32'd8, 32'd2, 3, 0, 1'b0);

        // Async reset in the middle of MUL_BUSY, between clock edges
        @(negedge clk);
        set_ops(4'b0001); src1 = 32'd5; src2 = 32'd7;
        @(negedge clk); #1;
        check("mid_mul_busy", 64'(busy), 64'd1);
        check("mid_mul_ina", 64'(mul_ina), 64'd5);
        #1;
        set_ops(4'b0000); rst = 1'b1;
        #1;
        check("rst_async_ctrl", 64'({mul_signed, div_start, hi_we, lo_we, busy, stallreq}), 64'd0);
        check("rst_async_data", 64'(mul_ina | mul_inb | hi_wdata | lo_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int we_cnt = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); #1;
                if (hi_we || busy) we_cnt++;
            end
            check("rst_no_write", 64'(we_cnt), 64'd0);
        end
        run_op("divu_9_3", 4'b0100, 32'd9, 32'd3, 4, 32'd0, 32'd3, 5, 1'b1);

        // Random back-to-back operations
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) ops = 4'($urandom_range(1, 15));
            else                          ops = 4'(4'b0001 << $urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 20));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (ops[3] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            lat = int'($urandom_range(1, 6));
            model(ops, a, b, lat, ehi, elo, estall, estart);
            run_op($sformatf("rand%0d", i), ops, a, b, lat, ehi, elo, estall, estart);
        end

        @(negedge clk);
        set_ops(4'b0000);
        @(negedge clk); #1;
        check("final_idle", 64'({busy, stallreq, hi_we}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
